// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// state encoding, default memory map and a small address helper.
package mem_ctrl_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_REQ  = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_REQ  = STATE_REQ,
        ST_DONE = STATE_DONE
    } state_e;

    localparam logic [31:0] MEM_BASE_DEF = 32'd1024;
    localparam int unsigned IDX_W_DEF    = 16;

    function automatic logic is_word_aligned(input logic [31:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_addr_xlate.sv
// Combinational byte-address to word-index translation with legality check
// (above base, word aligned, inside the indexable word range).
module mem_addr_xlate
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF
) (
    input  logic [31:0]      i_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_legal
);

    logic [31:0] w_offset;
    logic [31:0] w_word;

    // Range check uses the full 32-bit word offset; the index is truncated afterwards.
    always_comb begin
        w_offset = i_addr - MEM_BASE;
        w_word   = w_offset >> 2;
        o_idx    = w_word[IDX_W-1:0];
        o_legal  = (i_addr >= MEM_BASE) && is_word_aligned(i_addr) &&
                   ((w_word >> IDX_W) == 32'd0);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the word-addressed data memory: req/ack handshake,
// pipeline freeze while an access is outstanding, error pulse on bad address or timeout.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [IDX_W-1:0]  m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_m_req;
    logic                r_m_we;
    logic [IDX_W-1:0]    r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_err;

    logic [IDX_W-1:0]    w_idx;
    logic                w_legal;
    logic                w_req_any;

    mem_addr_xlate #(
        .MEM_BASE (MEM_BASE),
        .IDX_W    (IDX_W)
    ) u_xlate (
        .i_addr  (addr),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    assign w_req_any = rd_en | wr_en;

    // Access FSM with timeout counter and registered memory/pipeline outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any && w_legal) begin
                        r_state   <= ST_REQ;
                        r_m_req   <= 1'b1;
                        r_m_we    <= wr_en;
                        r_m_addr  <= w_idx;
                        r_m_wdata <= wr_data;
                        r_cnt     <= '0;
                    end else if (w_req_any) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (m_ack) begin
                        if (!r_m_we) begin
                            r_rd_data <= m_rdata;
                        end
                        r_m_req <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_m_req   <= 1'b0;
                        r_err     <= 1'b1;
                        r_rd_data <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Requests are still held here by the same instruction; never re-arm from DONE.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_m_req <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ((r_state == ST_IDLE) && !w_req_any) || (r_state == ST_DONE);
    assign rd_data = r_rd_data;
    assign err     = r_err;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset corner
// sequences and randomized accesses checked against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_at;
        logic [31:0] rdat;
    } stim_t;

    typedef struct {
        bit          legal;
        int          req_n;
        int          low_n;
        bit          err;
        logic [31:0] rd;
        logic [15:0] idx;
        bit          we;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        int          req_n;
        int          low_n;
        int          err_n;
        bit          err_done;
        logic [31:0] rd_done;
        logic [31:0] rd_after;
        logic [15:0] idx;
        bit          we;
        logic [31:0] wdata;
        int          hold_bad;
        bit          req_done;
        bit          req_after;
        bit          hung;
    } obs_t;

    mem_access_ctrl #(
        .DATA_W   (32),
        .MEM_BASE (32'd1024),
        .IDX_W    (16),
        .TIMEOUT  (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ready   (ready),
        .err     (err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one access from the address map and ack timing.
    function automatic exp_t model(input stim_t s, input logic [31:0] prev_rd);
        exp_t e;
        e.legal = (s.a >= 32'd1024) && (s.a % 32'd4 == 32'd0) &&
                  ((s.a - 32'd1024) / 32'd4 < 32'd65536);
        e.idx   = 16'((s.a - 32'd1024) / 32'd4);
        e.we    = s.wr;
        e.wdata = s.wd;
        if (!e.legal) begin
            e.req_n = 0;  e.low_n = 1;      e.err = 1'b1; e.rd = prev_rd;
        end else if (s.ack_at >= 1 && s.ack_at <= TMO) begin
            e.req_n = s.ack_at; e.low_n = s.ack_at + 1; e.err = 1'b0;
            e.rd = s.wr ? prev_rd : s.rdat;
        end else begin
            e.req_n = TMO; e.low_n = TMO + 1; e.err = 1'b1; e.rd = 32'd0;
        end
        return e;
    endfunction

    // Drives one instruction from IDLE through DONE, acting as the memory; returns in the next IDLE cycle.
    task automatic run_access(input stim_t s, output obs_t o);
        int n;
        bit fin;
        o = '{default: '0};
        rd_en = s.rd; wr_en = s.wr; addr = s.a; wr_data = s.wd;
        m_ack = 1'b0; m_rdata = s.rdat;
        n = 0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            if (err) o.err_n++;
            if (m_req) begin
                n++;
                if (n == 1) begin
                    o.idx = m_addr; o.we = m_we; o.wdata = m_wdata;
                end else if (m_addr !== o.idx || m_we !== o.we || m_wdata !== o.wdata) begin
                    o.hold_bad++;
                end
                m_ack = (n == s.ack_at);
            end else begin
                m_ack = 1'b0;
            end
            if (ready) begin
                fin = 1'b1;
                o.err_done = err; o.rd_done = rd_data; o.req_done = m_req;
                m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
            end else begin
                o.low_n++;
            end
            @(negedge clk);
        end
        o.hung  = !fin;
        o.req_n = n;
        #1;
        o.req_after = m_req;
        o.rd_after  = rd_data;
        if (err) o.err_n++;
        m_ack = 1'b0;
    endtask

    task automatic compare(input string tag, input exp_t e, input obs_t o);
        check({tag, ".hung"},      o.hung, 0);
        check({tag, ".req_cyc"},   o.req_n, e.req_n);
        check({tag, ".ready_low"}, o.low_n, e.low_n);
        check({tag, ".err_pulses"}, o.err_n, e.err ? 1 : 0);
        check({tag, ".err_done"},  o.err_done, e.err);
        check({tag, ".rd_done"},   o.rd_done, e.rd);
        check({tag, ".rd_after"},  o.rd_after, e.rd);
        check({tag, ".req_done"},  o.req_done, 0);
        check({tag, ".reissue"},   o.req_after, 0);
        if (e.legal) begin
            check({tag, ".m_addr"},  o.idx, e.idx);
            check({tag, ".m_we"},    o.we, e.we);
            check({tag, ".m_wdata"}, o.wdata, e.wdata);
            check({tag, ".hold"},    o.hold_bad, 0);
        end
    endtask

    task automatic idle_gap(input logic [31:0] exp_rd);
        rd_en = 1'b0; wr_en = 1'b0;
        m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        #1;
        check("idle.ready", ready, 1);
        check("idle.m_req", m_req, 0);
        @(negedge clk);
        #1;
        check("idle.rd_hold", rd_data, exp_rd);
        m_ack = 1'b0;
    endtask

    vec_t        vecs[11];
    logic [31:0] exp_rd;

    initial begin
        obs_t  o;
        stim_t s;
        exp_t  e;
        int    n;

        vecs[0]  = '{'{1'b1, 1'b0, 32'd1028,   32'd0,      2,  32'hDEAD_BEEF}, '{1'b1, 2,  3,  1'b0, 32'hDEAD_BEEF, 16'd1,     1'b0, 32'd0}};
        vecs[1]  = '{'{1'b0, 1'b1, 32'd1032,   32'd5,      1,  32'h0},         '{1'b1, 1,  2,  1'b0, 32'hDEAD_BEEF, 16'd2,     1'b1, 32'd5}};
        vecs[2]  = '{'{1'b1, 1'b0, 32'd1000,   32'd0,      1,  32'h1111_1111}, '{1'b0, 0,  1,  1'b1, 32'hDEAD_BEEF, 16'd0,     1'b0, 32'd0}};
        vecs[3]  = '{'{1'b0, 1'b1, 32'd1029,   32'd9,      1,  32'h0},         '{1'b0, 0,  1,  1'b1, 32'hDEAD_BEEF, 16'd0,     1'b0, 32'd0}};
        vecs[4]  = '{'{1'b1, 1'b0, 32'd263168, 32'd0,      1,  32'h2222_2222}, '{1'b0, 0,  1,  1'b1, 32'hDEAD_BEEF, 16'd0,     1'b0, 32'd0}};
        vecs[5]  = '{'{1'b1, 1'b0, 32'd263164, 32'd0,      15, 32'h1234_5678}, '{1'b1, 15, 16, 1'b0, 32'h1234_5678, 16'hFFFF,  1'b0, 32'd0}};
        vecs[6]  = '{'{1'b1, 1'b0, 32'd2048,   32'd0,      0,  32'h55},        '{1'b1, 15, 16, 1'b1, 32'd0,         16'd256,   1'b0, 32'd0}};
        vecs[7]  = '{'{1'b1, 1'b0, 32'd1024,   32'hCAFE,   1,  32'hA5A5_A5A5}, '{1'b1, 1,  2,  1'b0, 32'hA5A5_A5A5, 16'd0,     1'b0, 32'hCAFE}};
        vecs[8]  = '{'{1'b1, 1'b1, 32'd1040,   32'd77,     3,  32'hFFFF_0000}, '{1'b1, 3,  4,  1'b0, 32'hA5A5_A5A5, 16'd4,     1'b1, 32'd77}};
        vecs[9]  = '{'{1'b0, 1'b1, 32'd1036,   32'd1,      0,  32'h0},         '{1'b1, 15, 16, 1'b1, 32'd0,         16'd3,     1'b1, 32'd1}};
        vecs[10] = '{'{1'b1, 1'b0, 32'd1028,   32'd0,      16, 32'd9},         '{1'b1, 15, 16, 1'b1, 32'd0,         16'd1,     1'b0, 32'd0}};

        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wr_data = 32'd0;
        m_ack = 1'b0; m_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.m_req",   m_req, 0);
        check("rst.m_we",    m_we, 0);
        check("rst.m_addr",  m_addr, 0);
        check("rst.m_wdata", m_wdata, 0);
        check("rst.rd_data", rd_data, 0);
        check("rst.err",     err, 0);
        check("rst.ready",   ready, 1);
        rst = 1'b1;

        // Directed table, issued back to back (next instruction right after DONE).
        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].s, o);
            compare($sformatf("vec%0d", i), vecs[i].e, o);
        end
        exp_rd = 32'd0;

        s = '{1'b1, 1'b0, 32'd1100, 32'd0, 1, 32'h600D_F00D};
        e = model(s, exp_rd);
        run_access(s, o);
        compare("preload", e, o);
        exp_rd = e.rd;

        // Reset lands on the third REQ cycle of a load that never gets acked.
        rd_en = 1'b1; wr_en = 1'b0; addr = 32'd1028; m_ack = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(negedge clk);
            #1;
            if (m_req) n++;
        end
        check("mid.req_cycles", n, 3);
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        #1;
        check("mid.m_req",   m_req, 0);
        check("mid.rd_data", rd_data, 0);
        check("mid.m_addr",  m_addr, 0);
        check("mid.err",     err, 0);
        check("mid.ready",   ready, 1);
        rst = 1'b1;
        exp_rd = 32'd0;
        idle_gap(exp_rd);

        s = '{1'b1, 1'b0, 32'd1032, 32'd0, 1, 32'h0BAD_CAFE};
        e = model(s, exp_rd);
        run_access(s, o);
        compare("post_rst", e, o);
        exp_rd = e.rd;

        for (int k = 0; k < 80; k++) begin
            int op;
            int ak;
            op = $urandom_range(0, 2);
            s.rd = (op != 1);
            s.wr = (op != 0);
            ak = $urandom_range(0, 5);
            case (ak)
                3:       s.a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 65535)) + 32'($urandom_range(1, 3));
                4:       s.a = 32'($urandom_range(0, 1023));
                5:       s.a = 32'd263168 + 32'd4 * 32'($urandom_range(0, 4000));
                default: s.a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 65535));
            endcase
            s.ack_at = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 17);
            s.wd     = $urandom;
            s.rdat   = $urandom;
            if ($urandom_range(0, 2) == 0) idle_gap(exp_rd);
            e = model(s, exp_rd);
            run_access(s, o);
            compare($sformatf("rnd%0d", k), e, o);
            exp_rd = e.rd;
        end

        idle_gap(exp_rd);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
